// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// Module   : pc_fetch_pkg
// Brief    : Shared widths, PC increment and fetch-queue entry type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_INC     = 32'd4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small FIFO of fetched {pc, instr} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_entry,
    output fetch_entry_t                 rd_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    // Guarded locally so a misbehaving caller can never overflow/underflow.
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) begin
            r_mem[r_tail] <= wr_entry;
        end
    end

    assign rd_entry = w_empty ? '0 : r_mem[r_head];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register with redirect handling feeding a fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   w_count;
    logic               w_pop;
    logic               w_push;
    fetch_entry_t       w_wr_entry;
    fetch_entry_t       w_head;

    assign w_pop  = out_valid && out_ready;
    // A redirect suppresses the push of the wrong-path word fetched this cycle.
    assign w_push = !redirect_valid && ((w_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC & ALIGN_MASK;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & ALIGN_MASK;
        end else if (w_push) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = imem_data;

    fetch_fifo #(
        .DEPTH    (DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (redirect_valid),
        .wr_entry (w_wr_entry),
        .rd_entry (w_head),
        .count    (w_count)
    );

    assign imem_addr = r_pc;
    assign out_valid = (w_count != '0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed vector table plus randomized scoreboard run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    pc_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .DEPTH          (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h3800_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_data = mem_word(imem_addr);

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t        tbl[$];
    ent_t        mq[$];
    logic [31:0] mpc;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // mode 0: no check, 1: check against v, 2: check against the scoreboard
    task automatic step(input int mode, input vec_t v);
        logic        ev;
        logic [31:0] epc, einstr, eaddr;
        logic        pop, push;
        @(negedge clk);
        reset          = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        out_ready      = v.rdy;
        #1;
        if (mode == 1) begin
            ev = v.ev; epc = v.ev ? v.epc : 32'h0;
            einstr = v.ev ? mem_word(v.epc) : 32'h0; eaddr = v.eaddr;
        end else begin
            ev = (mq.size() != 0);
            epc = ev ? mq[0].pc : 32'h0;
            einstr = ev ? mq[0].instr : 32'h0;
            eaddr = mpc;
        end
        if (mode != 0) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            chk("out_pc",    out_pc,    epc);
            chk("out_instr", out_instr, einstr);
            chk("imem_addr", imem_addr, eaddr);
        end
        if (v.rst) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (v.rv) begin
            mq.delete();
            mpc = v.rpc & 32'hFFFF_FFFC;
        end else begin
            pop  = (mq.size() != 0) && v.rdy;
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(ent_t'{pc: mpc, instr: mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        mpc = RESET_PC;

        // reset release with out_ready=1
        add(1,0,32'h0,1, 0,32'h0,32'h0);
        add(0,0,32'h0,1, 0,32'h0,32'h0);
        add(0,0,32'h0,1, 1,32'h0,32'h4);
        add(0,0,32'h0,1, 1,32'h4,32'h8);
        add(0,0,32'h0,1, 1,32'h8,32'hC);
        add(0,0,32'h0,1, 1,32'hC,32'h10);
        add(1,0,32'h0,0, 1,32'h10,32'h14);
        // stalled decode: queue fills to DEPTH, then drains in order
        add(0,0,32'h0,0, 0,32'h0,32'h0);
        add(0,0,32'h0,0, 1,32'h0,32'h4);
        add(0,0,32'h0,0, 1,32'h0,32'h8);
        add(0,0,32'h0,0, 1,32'h0,32'h8);
        add(0,0,32'h0,0, 1,32'h0,32'h8);
        add(0,0,32'h0,1, 1,32'h0,32'h8);
        add(0,0,32'h0,1, 1,32'h4,32'hC);
        add(0,0,32'h0,1, 1,32'h8,32'h10);
        add(0,0,32'h0,1, 1,32'hC,32'h14);
        // redirect while full with a pop in the same cycle
        add(0,1,32'h100,1, 1,32'h10,32'h18);
        add(0,0,32'h0,1,   0,32'h0,32'h100);
        add(0,0,32'h0,1,   1,32'h100,32'h104);
        // unaligned redirect, then wrap at the top of the address space
        add(0,1,32'h103,1,       1,32'h104,32'h108);
        add(0,1,32'hFFFF_FFFC,1, 0,32'h0,32'h100);
        add(0,0,32'h0,0, 0,32'h0,32'hFFFF_FFFC);
        add(0,0,32'h0,0, 1,32'hFFFF_FFFC,32'h0);
        add(0,0,32'h0,1, 1,32'hFFFF_FFFC,32'h4);
        add(0,0,32'h0,1, 1,32'h0,32'h8);
        // reset beats a simultaneous redirect on a full queue
        add(1,1,32'h200,1, 1,32'h4,32'hC);
        add(0,0,32'h0,1,   0,32'h0,RESET_PC);
        add(0,0,32'h0,1,   1,RESET_PC,RESET_PC + 32'h4);
        add(0,0,32'h0,1,   1,RESET_PC + 32'h4,RESET_PC + 32'h8);

        v = '{rst:1'b1, rv:1'b0, rpc:32'h0, rdy:1'b0, ev:1'b0, epc:32'h0, eaddr:32'h0};
        repeat (2) step(0, v);

        for (int i = 0; i < tbl.size(); i++) step(1, tbl[i]);

        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(0, 49) == 0);
            v.rv  = ($urandom_range(0, 9) == 0);
            v.rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                : $urandom;
            v.rdy = $urandom_range(0, 1) == 1;
            step(2, v);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
